pipeline_stage_4_mem: RTL and testbench
=======================================

# pipeline_stage_4_mem

Memory stage of the 5-stage MIPS pipeline, between the EX/MEM register and the write-back stage. Performs data-memory loads/stores over a req/ack handshake, services the 32-bit I/O port, and owns the MEM/WB pipeline register that feeds write-back (WB control, memory data, I/O data, ALU result, destination register). Stalls the upstream pipeline while an external memory access is outstanding.

## Interface
- No parameters; all widths fixed.
- clk  in  1  pipeline clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- EXMEM_WB  in  4  WB control: [3] break, [2:1] source select (10=IO, 01=memory, else ALU), [0] register write enable.
- EXMEM_M  in  3  MEM control: [2] IO access, [1] read, [0] write.
- EXMEM_ALU  in  32  ALU result; memory byte address for loads/stores.
- EXMEM_WData  in  32  store data (memory or IO out).
- EXMEM_Waddr  in  5  destination register.
- mem_rdata  in  32  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completes current request this cycle.
- io_in  in  32  external input port.
- mem_req  out  1  memory request (combinational).
- mem_we  out  1  write strobe, valid with mem_req.
- mem_addr  out  32  = EXMEM_ALU.
- mem_wdata  out  32  = EXMEM_WData.
- io_out  out  32  registered output port.
- mem_stall  out  1  hold IF/ID/EX and EX/MEM registers this cycle.
- stall_cnt  out  16  saturating count of stalled cycles.
- MEMWB_WB  out  4  registered WB control.
- MEMWB_MData, MEMWB_IO, MEMWB_ALU  out  32 each  registered data.
- MEMWB_Waddr  out  5  registered destination.

## Operation
- mem_access = ~EXMEM_M[2] & (EXMEM_M[1] | EXMEM_M[0]). If EXMEM_M[1] and EXMEM_M[0] are both set, treat as write (mem_we=1); read data discarded.
- FSM states IDLE, WAIT (reset: IDLE).
  - IDLE: mem_req=mem_access. mem_access & mem_ack -> complete, stay IDLE, mem_stall=0. mem_access & ~mem_ack -> mem_stall=1, go WAIT. No access -> mem_stall=0.
  - WAIT: mem_req=1, mem_we held from EXMEM_M[0]. ~mem_ack -> mem_stall=1, stay. mem_ack -> mem_stall=0, complete, go IDLE.
- IO access (EXMEM_M[2]=1): single-cycle, never stalls, mem_req=0. Write -> io_out <= EXMEM_WData. Read -> MEMWB_IO <= io_in.
- MEM/WB register, each edge:
  - mem_stall=1: load bubble: MEMWB_WB <= 0; other MEMWB fields hold. Ensures no duplicate register write and no early break.
  - mem_stall=0: MEMWB_WB <= EXMEM_WB, MEMWB_ALU <= EXMEM_ALU, MEMWB_Waddr <= EXMEM_Waddr; MEMWB_MData <= mem_rdata if completed read, else 0; MEMWB_IO <= io_in if IO read, else 0.
- Break (EXMEM_WB[3]) passes unaltered; no action in this stage.
- stall_cnt increments each cycle mem_stall=1, saturates at 16'hFFFF.

## Timing
- Reset values: MEMWB_* = 0, io_out = 0, stall_cnt = 0, state IDLE; hence mem_stall=0, mem_req=0.
- Latency EX/MEM -> MEM/WB: 1 cycle with zero-wait memory or non-memory op; 1+N cycles with N wait cycles (mem_stall high N cycles).
- mem_req, mem_we, mem_addr, mem_wdata stable from first request cycle to ack cycle inclusive (upstream held by mem_stall).
- mem_ack while mem_req=0 is ignored.
- Reset asserted in WAIT: immediate return to IDLE, request dropped, MEMWB cleared; memory must tolerate abandoned request.
- Back-to-back accesses: next request may start the cycle after ack; no idle cycle required.
- io_out updates at the edge ending the IO write cycle; io_in sampled at that edge.

## Test plan
- Reset: rst pulse mid-run -> all MEMWB outputs 0, io_out 0, stall_cnt 0, mem_stall 0 asynchronously.
- Zero-wait load: EXMEM_M=3'b010, ALU=0x40, mem_ack=1 same cycle, mem_rdata=0xDEADBEEF -> mem_stall never high; next cycle MEMWB_MData=0xDEADBEEF, MEMWB_ALU=0x40, MEMWB_WB=EXMEM_WB.
- 3-wait store: EXMEM_M=3'b001, WData=0x1234, ack on 4th cycle -> mem_req/mem_we high 4 cycles, mem_stall high 3, MEMWB_WB=0 for 3 edges, stall_cnt=3.
- IO: write 0xA5A5A5A5 (M=3'b101) -> io_out=0xA5A5A5A5 next cycle; read (M=3'b110, WB=4'b0101, io_in=0x77) -> MEMWB_IO=0x77, no mem_req.
- Back-to-back loads, second with 1 wait -> first completes no stall, second stalls 1 cycle, both data correct in order.
- ALU op with break (WB=4'b1000, M=0) -> passes to MEMWB_WB=4'b1000 after 1 cycle; reset during WAIT drops mem_req same cycle.

Source files
------------

// File: rtl/pipeline_stage_4_mem.sv
// MIPS memory stage: data memory req/ack access, 32-bit I/O port, MEM/WB register.
// Stalls upstream while an external memory access is outstanding.
module pipeline_stage_4_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  EXMEM_WB,
  input  logic [2:0]  EXMEM_M,
  input  logic [31:0] EXMEM_ALU,
  input  logic [31:0] EXMEM_WData,
  input  logic [4:0]  EXMEM_Waddr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  input  logic [31:0] io_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] io_out,
  output logic        mem_stall,
  output logic [15:0] stall_cnt,
  output logic [3:0]  MEMWB_WB,
  output logic [31:0] MEMWB_MData,
  output logic [31:0] MEMWB_IO,
  output logic [31:0] MEMWB_ALU,
  output logic [4:0]  MEMWB_Waddr
);

  typedef enum logic {IDLE, WAIT} state_t;
  state_t state;

  logic mem_access;
  logic done;
  logic mem_rd;
  logic io_wr;
  logic io_rd;

  assign mem_access = ~EXMEM_M[2] & (EXMEM_M[1] | EXMEM_M[0]);
  // Gated by rst so an abandoned request drops while reset is held
  assign mem_req    = ~rst & ((state == WAIT) | mem_access);
  assign mem_we     = mem_req & EXMEM_M[0];
  assign mem_addr   = EXMEM_ALU;
  assign mem_wdata  = EXMEM_WData;
  assign mem_stall  = mem_req & ~mem_ack;
  assign done       = mem_req & mem_ack;
  // Read+write together is a write; read data is discarded
  assign mem_rd     = done & EXMEM_M[1] & ~EXMEM_M[0];
  assign io_wr      = EXMEM_M[2] & EXMEM_M[0];
  assign io_rd      = EXMEM_M[2] & EXMEM_M[1] & ~EXMEM_M[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: if (mem_access & ~mem_ack) state <= WAIT;
        WAIT: if (mem_ack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_out <= '0;
    end else if (io_wr) begin
      io_out <= EXMEM_WData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (mem_stall && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  // A stalled cycle inserts a bubble so write-back never sees the op twice
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MEMWB_WB    <= '0;
      MEMWB_MData <= '0;
      MEMWB_IO    <= '0;
      MEMWB_ALU   <= '0;
      MEMWB_Waddr <= '0;
    end else if (mem_stall) begin
      MEMWB_WB    <= '0;
    end else begin
      MEMWB_WB    <= EXMEM_WB;
      MEMWB_ALU   <= EXMEM_ALU;
      MEMWB_Waddr <= EXMEM_Waddr;
      MEMWB_MData <= mem_rd ? mem_rdata : 32'd0;
      MEMWB_IO    <= io_rd ? io_in : 32'd0;
    end
  end

endmodule

// File: tb/tb_pipeline_stage_4_mem.sv
// Scoreboard bench for the memory stage: expected MEM/WB contents are
// queued when an op is issued and compared when the op leaves the stage.
module tb_pipeline_stage_4_mem;

  logic        clk = 0;
  logic        rst;
  logic [3:0]  exmem_wb;
  logic [2:0]  exmem_m;
  logic [31:0] exmem_alu;
  logic [31:0] exmem_wdata;
  logic [4:0]  exmem_waddr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] io_in;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] io_out;
  logic        mem_stall;
  logic [15:0] stall_cnt;
  logic [3:0]  memwb_wb;
  logic [31:0] memwb_mdata;
  logic [31:0] memwb_io;
  logic [31:0] memwb_alu;
  logic [4:0]  memwb_waddr;

  typedef struct {
    logic [3:0]  wb;
    logic [31:0] mdata;
    logic [31:0] io;
    logic [31:0] alu;
    logic [4:0]  waddr;
  } exp_t;

  exp_t sb[$];
  int passed = 0;
  int total = 0;

  pipeline_stage_4_mem dut (
    .clk(clk), .rst(rst),
    .EXMEM_WB(exmem_wb), .EXMEM_M(exmem_m), .EXMEM_ALU(exmem_alu),
    .EXMEM_WData(exmem_wdata), .EXMEM_Waddr(exmem_waddr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .io_in(io_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .io_out(io_out), .mem_stall(mem_stall),
    .stall_cnt(stall_cnt), .MEMWB_WB(memwb_wb), .MEMWB_MData(memwb_mdata),
    .MEMWB_IO(memwb_io), .MEMWB_ALU(memwb_alu), .MEMWB_Waddr(memwb_waddr)
  );

  always #5 clk = ~clk;

  task automatic nop();
    exmem_wb = '0; exmem_m = '0; exmem_alu = '0;
    exmem_wdata = '0; exmem_waddr = '0; mem_ack = 0;
  endtask

  // Issue one op; ack arrives after 'waits' wait cycles. Returns observed
  // request/stall counts and number of stalled edges that leaked WB bits.
  task automatic drive_op(
    input logic [3:0] wb, input logic [2:0] m, input logic [31:0] alu,
    input logic [31:0] wd, input logic [4:0] wa, input logic [31:0] rd,
    input int waits, output int stalls, output int reqs, output int wes,
    output int bub);
    exp_t e;
    exmem_wb = wb; exmem_m = m; exmem_alu = alu;
    exmem_wdata = wd; exmem_waddr = wa; mem_rdata = rd;
    e.wb = wb;
    e.mdata = (!m[2] && m[1] && !m[0]) ? rd : 32'd0;
    e.io = (m[2] && m[1] && !m[0]) ? io_in : 32'd0;
    e.alu = alu;
    e.waddr = wa;
    sb.push_back(e);
    stalls = 0; reqs = 0; wes = 0; bub = 0;
    for (int c = 0; c <= waits; c++) begin
      mem_ack = (c == waits);
      #1;
      if (mem_req) reqs++;
      if (mem_we) wes++;
      if (mem_stall) stalls++;
      @(posedge clk); #1;
      if (c < waits && memwb_wb !== 4'd0) bub++;
    end
    nop();
  endtask

  task automatic test_reset();
    rst = 1;
    nop();
    mem_rdata = '0; io_in = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({memwb_wb, memwb_mdata, memwb_io, memwb_alu, memwb_waddr} !== '0) begin
      $display("FAIL reset_memwb: got %h/%h/%h/%h/%h required 0",
        memwb_wb, memwb_mdata, memwb_io, memwb_alu, memwb_waddr);
    end else passed++;
    total++;
    if ({io_out, stall_cnt, mem_stall, mem_req} !== '0) begin
      $display("FAIL reset_misc: io_out %h cnt %h stall %b req %b required 0",
        io_out, stall_cnt, mem_stall, mem_req);
    end else passed++;
    rst = 0;
  endtask

  task automatic test_zero_wait_load();
    int st, rq, we, bb;
    exp_t e;
    drive_op(4'b0011, 3'b010, 32'h40, 32'h0, 5'd7, 32'hDEADBEEF, 0, st, rq, we, bb);
    e = sb.pop_front();
    total++;
    if (st !== 0 || rq !== 1 || we !== 0) begin
      $display("FAIL zw_load_hs: stall %0d req %0d we %0d required 0/1/0", st, rq, we);
    end else passed++;
    total++;
    if ({memwb_wb, memwb_mdata, memwb_io, memwb_alu, memwb_waddr} !==
        {e.wb, e.mdata, e.io, e.alu, e.waddr}) begin
      $display("FAIL zw_load_data: got %h %h %h %h %h required %h %h %h %h %h",
        memwb_wb, memwb_mdata, memwb_io, memwb_alu, memwb_waddr,
        e.wb, e.mdata, e.io, e.alu, e.waddr);
    end else passed++;
  endtask

  task automatic test_store_waits();
    int st, rq, we, bb;
    logic [15:0] c0;
    exp_t e;
    c0 = stall_cnt;
    drive_op(4'b0000, 3'b001, 32'h80, 32'h1234, 5'd0, 32'h5555, 3, st, rq, we, bb);
    e = sb.pop_front();
    total++;
    if (rq !== 4 || we !== 4 || st !== 3) begin
      $display("FAIL store_hs: req %0d we %0d stall %0d required 4/4/3", rq, we, st);
    end else passed++;
    total++;
    if (bb !== 0) begin
      $display("FAIL store_bubble: leaked %0d required 0", bb);
    end else passed++;
    total++;
    if (stall_cnt !== c0 + 16'd3) begin
      $display("FAIL store_cnt: got %0d required %0d", stall_cnt, c0 + 16'd3);
    end else passed++;
    total++;
    if ({memwb_wb, memwb_mdata, memwb_io, memwb_alu, memwb_waddr} !==
        {e.wb, e.mdata, e.io, e.alu, e.waddr}) begin
      $display("FAIL store_data: got %h %h %h %h required %h %h %h %h",
        memwb_wb, memwb_mdata, memwb_alu, memwb_waddr,
        e.wb, e.mdata, e.alu, e.waddr);
    end else passed++;
  endtask

  task automatic test_io();
    int st, rq, we, bb;
    exp_t e;
    drive_op(4'b0000, 3'b101, 32'h0, 32'hA5A5A5A5, 5'd0, 32'h0, 0, st, rq, we, bb);
    e = sb.pop_front();
    total++;
    if (io_out !== 32'hA5A5A5A5 || rq !== 0) begin
      $display("FAIL io_write: io_out %h req %0d required a5a5a5a5/0", io_out, rq);
    end else passed++;
    io_in = 32'h77;
    drive_op(4'b0101, 3'b110, 32'h3, 32'h0, 5'd9, 32'hCAFE, 0, st, rq, we, bb);
    io_in = 32'h0;
    e = sb.pop_front();
    total++;
    if (rq !== 0 || st !== 0) begin
      $display("FAIL io_read_req: req %0d stall %0d required 0/0", rq, st);
    end else passed++;
    total++;
    if ({memwb_wb, memwb_mdata, memwb_io, memwb_alu, memwb_waddr} !==
        {e.wb, e.mdata, e.io, e.alu, e.waddr}) begin
      $display("FAIL io_read_data: got %h %h %h %h %h required %h %h %h %h %h",
        memwb_wb, memwb_mdata, memwb_io, memwb_alu, memwb_waddr,
        e.wb, e.mdata, e.io, e.alu, e.waddr);
    end else passed++;
  endtask

  task automatic test_reset_midrun();
    rst = 1;
    #1;
    total++;
    if ({io_out, stall_cnt, mem_stall, memwb_wb, memwb_io, memwb_alu} !== '0) begin
      $display("FAIL reset_async: io_out %h cnt %h stall %b wb %h io %h alu %h required 0",
        io_out, stall_cnt, mem_stall, memwb_wb, memwb_io, memwb_alu);
    end else passed++;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_back_to_back();
    int st, rq, we, bb;
    logic [15:0] c0;
    exp_t e;
    c0 = stall_cnt;
    drive_op(4'b0011, 3'b010, 32'h100, 32'h0, 5'd1, 32'h11111111, 0, st, rq, we, bb);
    e = sb.pop_front();
    total++;
    if (st !== 0 || memwb_mdata !== e.mdata || memwb_alu !== e.alu) begin
      $display("FAIL b2b_first: stall %0d data %h alu %h required 0 %h %h",
        st, memwb_mdata, memwb_alu, e.mdata, e.alu);
    end else passed++;
    drive_op(4'b0011, 3'b010, 32'h104, 32'h0, 5'd2, 32'h22222222, 1, st, rq, we, bb);
    e = sb.pop_front();
    total++;
    if (st !== 1 || bb !== 0 || stall_cnt !== c0 + 16'd1) begin
      $display("FAIL b2b_second_stall: stall %0d leak %0d cnt %0d required 1 0 %0d",
        st, bb, stall_cnt, c0 + 16'd1);
    end else passed++;
    total++;
    if ({memwb_wb, memwb_mdata, memwb_alu, memwb_waddr} !==
        {e.wb, e.mdata, e.alu, e.waddr}) begin
      $display("FAIL b2b_second_data: got %h %h %h %h required %h %h %h %h",
        memwb_wb, memwb_mdata, memwb_alu, memwb_waddr,
        e.wb, e.mdata, e.alu, e.waddr);
    end else passed++;
  endtask

  task automatic test_break();
    int st, rq, we, bb;
    exp_t e;
    drive_op(4'b1000, 3'b000, 32'h99, 32'h0, 5'd3, 32'hFFFF0000, 0, st, rq, we, bb);
    e = sb.pop_front();
    total++;
    if (rq !== 0 || st !== 0) begin
      $display("FAIL break_req: req %0d stall %0d required 0/0", rq, st);
    end else passed++;
    total++;
    if ({memwb_wb, memwb_mdata, memwb_alu, memwb_waddr} !==
        {e.wb, e.mdata, e.alu, e.waddr}) begin
      $display("FAIL break_pass: got %h %h %h %h required %h %h %h %h",
        memwb_wb, memwb_mdata, memwb_alu, memwb_waddr,
        e.wb, e.mdata, e.alu, e.waddr);
    end else passed++;
  endtask

  task automatic test_reset_in_wait();
    exmem_wb = 4'b0011; exmem_m = 3'b010; exmem_alu = 32'h200;
    exmem_waddr = 5'd4; mem_ack = 0;
    @(posedge clk); #1;
    total++;
    if (mem_req !== 1'b1 || mem_stall !== 1'b1 || memwb_alu !== 32'h99) begin
      $display("FAIL wait_entry: req %b stall %b alu %h required 1 1 99",
        mem_req, mem_stall, memwb_alu);
    end else passed++;
    rst = 1;
    #1;
    total++;
    if ({mem_req, mem_stall, stall_cnt, memwb_wb, memwb_alu, memwb_waddr} !== '0) begin
      $display("FAIL reset_wait: req %b stall %b cnt %h wb %h alu %h wa %h required 0",
        mem_req, mem_stall, stall_cnt, memwb_wb, memwb_alu, memwb_waddr);
    end else passed++;
    nop();
    @(posedge clk); #1;
    rst = 0;
    #1;
    total++;
    if (mem_req !== 1'b0 || mem_stall !== 1'b0) begin
      $display("FAIL reset_wait_idle: req %b stall %b required 0/0", mem_req, mem_stall);
    end else passed++;
  endtask

  initial begin
    test_reset();
    test_zero_wait_load();
    test_store_waits();
    test_io();
    test_reset_midrun();
    test_back_to_back();
    test_break();
    test_reset_in_wait();
    total++;
    if (sb.size() !== 0) begin
      $display("FAIL scoreboard_left: got %0d required 0", sb.size());
    end else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
